// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared types and constants for the clock time-keeping datapath.
//   state_e      : time_set_ctrl FSM states
//   edit_field_e : codes presented on o_edit_field
//   HOUR_MAX     : largest legal hour value (24-hour clock)
//   MIN_MAX      : largest legal minute/second value
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_HOUR,
    SET_MIN,
    SET_SEC,
    COMMIT
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HOUR = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } edit_field_e;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  // Field highlighted on the display for a given controller state.
  function automatic edit_field_e field_of(input state_e s);
    case (s)
      SET_HOUR: return FIELD_HOUR;
      SET_MIN:  return FIELD_MIN;
      SET_SEC:  return FIELD_SEC;
      default:  return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wrap_updown.sv
// -----------------------------------------------------------------------------
// wrap_updown
// Combinational modulo (MAX_VAL+1) up/down step for one time field.
//   value      : current field value
//   up         : step +1, wrapping MAX_VAL -> 0
//   down       : step -1, wrapping 0 -> MAX_VAL
//   next_value : stepped value; unchanged when neither or both are set
// -----------------------------------------------------------------------------
module wrap_updown #(
  parameter int WIDTH   = 6,
  parameter int MAX_VAL = 59
) (
  input  logic [WIDTH-1:0] value,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] next_value
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    next_value = value;
    if (up && !down) begin
      // >= rather than == so a stray out-of-range value still wraps to 0.
      next_value = (value >= MAX_W) ? '0 : value + 1'b1;
    end else if (down && !up) begin
      next_value = (value == '0) ? MAX_W : value - 1'b1;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Mode controller between the button debouncers and the sec/min/hour counter
// chain. In RUN the counters advance; a mode press snapshots the current time
// into edit registers and freezes the counters while the user steps through
// hour, minute and second. The final mode press issues a one-cycle parallel
// load; P_TIMEOUT_SEC seconds without a button abandons the edit unloaded.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   i_one_sec_tick    : free-running 1 Hz single-cycle pulse
//   i_btn_mode/up/down: debounced single-cycle button pulses
//   i_hour/i_min/i_sec: live counter values, captured on edit entry
//   o_run_en          : counters advance while 1
//   o_load            : one-cycle load strobe
//   o_load_hour/min/sec: edit registers (valid with o_load)
//   o_edit_field      : 0 none, 1 hour, 2 minute, 3 second
//   o_blink           : visibility of the edited field, 1 = shown
// All outputs are registered.
// -----------------------------------------------------------------------------
module time_set_ctrl #(
  parameter int P_HOUR_BIT    = 5,
  parameter int P_MIN_BIT     = 6,
  parameter int P_TIMEOUT_SEC = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_one_sec_tick,
  input  logic                  i_btn_mode,
  input  logic                  i_btn_up,
  input  logic                  i_btn_down,
  input  logic [P_HOUR_BIT-1:0] i_hour,
  input  logic [P_MIN_BIT-1:0]  i_min,
  input  logic [P_MIN_BIT-1:0]  i_sec,
  output logic                  o_run_en,
  output logic                  o_load,
  output logic [P_HOUR_BIT-1:0] o_load_hour,
  output logic [P_MIN_BIT-1:0]  o_load_min,
  output logic [P_MIN_BIT-1:0]  o_load_sec,
  output logic [1:0]            o_edit_field,
  output logic                  o_blink
);

  import clock_pkg::*;

  localparam int                    TO_W       = $clog2(P_TIMEOUT_SEC + 1);
  localparam logic [TO_W-1:0]       TIMEOUT_W  = TO_W'(P_TIMEOUT_SEC);
  localparam logic [P_HOUR_BIT-1:0] HOUR_MAX_W = P_HOUR_BIT'(HOUR_MAX);
  localparam logic [P_MIN_BIT-1:0]  MIN_MAX_W  = P_MIN_BIT'(MIN_MAX);

  state_e                state_q, state_d;
  logic [P_HOUR_BIT-1:0] hour_q, hour_d, hour_adj;
  logic [P_MIN_BIT-1:0]  min_q, min_d, min_adj;
  logic [P_MIN_BIT-1:0]  sec_q, sec_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic                  blink_q, blink_d;
  logic                  run_en_q, run_en_d;
  logic                  load_q, load_d;
  logic [1:0]            edit_field_q, edit_field_d;

  // A single up or down press adjusts; both at once cancel out.
  logic adj_pulse;
  logic btn_any;
  assign adj_pulse = i_btn_up ^ i_btn_down;
  assign btn_any   = i_btn_mode | i_btn_up | i_btn_down;

  wrap_updown #(
    .WIDTH   (P_HOUR_BIT),
    .MAX_VAL (HOUR_MAX)
  ) u_hour_wrap (
    .value      (hour_q),
    .up         (i_btn_up),
    .down       (i_btn_down),
    .next_value (hour_adj)
  );

  wrap_updown #(
    .WIDTH   (P_MIN_BIT),
    .MAX_VAL (MIN_MAX)
  ) u_min_wrap (
    .value      (min_q),
    .up         (i_btn_up),
    .down       (i_btn_down),
    .next_value (min_adj)
  );

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    to_d    = to_q;
    blink_d = blink_q;

    case (state_q)
      RUN: begin
        to_d    = '0;
        blink_d = 1'b1;
        if (i_btn_mode) begin
          state_d = SET_HOUR;
          // Clamp so the edit registers never hold an illegal time.
          hour_d  = (i_hour > HOUR_MAX_W) ? '0 : i_hour;
          min_d   = (i_min  > MIN_MAX_W)  ? '0 : i_min;
          sec_d   = (i_sec  > MIN_MAX_W)  ? '0 : i_sec;
        end
      end

      SET_HOUR, SET_MIN, SET_SEC: begin
        if (i_btn_mode) begin
          case (state_q)
            SET_HOUR: state_d = SET_MIN;
            SET_MIN:  state_d = SET_SEC;
            default:  state_d = COMMIT;
          endcase
          to_d    = '0;
          blink_d = 1'b1;
        end else if (adj_pulse) begin
          case (state_q)
            SET_HOUR: hour_d = hour_adj;
            SET_MIN:  min_d  = min_adj;
            default:  sec_d  = '0;   // seconds can only be zeroed
          endcase
          to_d    = '0;
          blink_d = 1'b1;
        end else begin
          if (i_one_sec_tick) begin
            blink_d = ~blink_q;
          end
          // Up+down together still counts as activity, and any button
          // outranks a coincident expiry.
          if (btn_any) begin
            to_d = '0;
          end else if (i_one_sec_tick) begin
            if ((to_q + 1'b1) == TIMEOUT_W) begin
              state_d = RUN;
              to_d    = '0;
              blink_d = 1'b1;
            end else begin
              to_d = to_q + 1'b1;
            end
          end
        end
      end

      COMMIT: begin
        state_d = RUN;
        blink_d = 1'b1;
      end

      default: begin
        state_d = RUN;
        to_d    = '0;
        blink_d = 1'b1;
      end
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // still line up with the state they describe.
    run_en_d     = (state_d == RUN);
    load_d       = (state_d == COMMIT);
    edit_field_d = field_of(state_d);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous and covers every flop, including the edit
    // registers, so a reset mid-edit leaves nothing of the edit behind.
    if (reset) begin
      state_q      <= RUN;
      hour_q       <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      to_q         <= '0;
      blink_q      <= 1'b1;
      run_en_q     <= 1'b1;
      load_q       <= 1'b0;
      edit_field_q <= FIELD_NONE;
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      to_q         <= to_d;
      blink_q      <= blink_d;
      run_en_q     <= run_en_d;
      load_q       <= load_d;
      edit_field_q <= edit_field_d;
    end
  end

  assign o_run_en     = run_en_q;
  assign o_load       = load_q;
  assign o_load_hour  = hour_q;
  assign o_load_min   = min_q;
  assign o_load_sec   = sec_q;
  assign o_edit_field = edit_field_q;
  assign o_blink      = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Scoreboard bench for time_set_ctrl. The driver applies one cycle of inputs,
// advances a behavioural model of the set-mode rules and queues the outputs
// the model predicts after the edge. An independent monitor pops one entry on
// every falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

  localparam int HB = 5;
  localparam int MB = 6;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_one_sec_tick;
  logic          i_btn_mode;
  logic          i_btn_up;
  logic          i_btn_down;
  logic [HB-1:0] i_hour;
  logic [MB-1:0] i_min;
  logic [MB-1:0] i_sec;
  logic          o_run_en;
  logic          o_load;
  logic [HB-1:0] o_load_hour;
  logic [MB-1:0] o_load_min;
  logic [MB-1:0] o_load_sec;
  logic [1:0]    o_edit_field;
  logic          o_blink;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .P_HOUR_BIT    (HB),
    .P_MIN_BIT     (MB),
    .P_TIMEOUT_SEC (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_one_sec_tick (i_one_sec_tick),
    .i_btn_mode     (i_btn_mode),
    .i_btn_up       (i_btn_up),
    .i_btn_down     (i_btn_down),
    .i_hour         (i_hour),
    .i_min          (i_min),
    .i_sec          (i_sec),
    .o_run_en       (o_run_en),
    .o_load         (o_load),
    .o_load_hour    (o_load_hour),
    .o_load_min     (o_load_min),
    .o_load_sec     (o_load_sec),
    .o_edit_field   (o_edit_field),
    .o_blink        (o_blink)
  );

  typedef struct {
    int run_en;
    int load;
    int field;
    int blink;
    int h;
    int m;
    int s;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time,
               actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: mode 0 = running, 1..3 = editing hour/min/sec,
  // 4 = load cycle. Fields step with modular arithmetic.
  // ---------------------------------------------------------------------------
  int m_mode, m_h, m_m, m_s, m_idle, m_blink;

  task automatic model_step(input bit rst, input bit bm, input bit bu,
                            input bit bd, input bit tk,
                            input int h, input int mi, input int s);
    bit adj;
    if (rst) begin
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_idle = 0; m_blink = 1;
      return;
    end
    adj = (bu != bd);
    if (m_mode == 0) begin
      m_blink = 1;
      if (bm) begin
        m_mode = 1;
        m_h = (h < 24) ? h : 0;
        m_m = (mi < 60) ? mi : 0;
        m_s = (s < 60) ? s : 0;
        m_idle = 0;
      end
    end else if (m_mode == 4) begin
      m_mode = 0;
      m_blink = 1;
    end else if (bm) begin
      m_mode = m_mode + 1;
      m_idle = 0;
      m_blink = 1;
    end else if (adj) begin
      case (m_mode)
        1:       m_h = (m_h + (bu ? 1 : 23)) % 24;
        2:       m_m = (m_m + (bu ? 1 : 59)) % 60;
        default: m_s = 0;
      endcase
      m_idle = 0;
      m_blink = 1;
    end else begin
      if (bu && bd) m_idle = 0;
      else if (tk) m_idle = m_idle + 1;
      if (m_idle == TO) begin
        m_mode = 0;
        m_idle = 0;
        m_blink = 1;
      end else if (tk) begin
        m_blink = 1 - m_blink;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.run_en = (m_mode == 0) ? 1 : 0;
    e.load   = (m_mode == 4) ? 1 : 0;
    e.field  = (m_mode >= 1 && m_mode <= 3) ? m_mode : 0;
    e.blink  = m_blink;
    e.h      = m_h;
    e.m      = m_m;
    e.s      = m_s;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  int cur_h = 0, cur_m = 0, cur_s = 0;

  task automatic drive(input bit rst, input bit bm, input bit bu,
                       input bit bd, input bit tk);
    reset          = rst;
    i_btn_mode     = bm;
    i_btn_up       = bu;
    i_btn_down     = bd;
    i_one_sec_tick = tk;
    i_hour         = HB'(cur_h);
    i_min          = MB'(cur_m);
    i_sec          = MB'(cur_s);
    model_step(rst, bm, bu, bd, tk, cur_h, cur_m, cur_s);
    @(posedge clk);
    sb_q.push_back(model_out());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic press_mode(); drive(0, 1, 0, 0, 0); endtask
  task automatic press_up();   drive(0, 0, 1, 0, 0); endtask
  task automatic press_down(); drive(0, 0, 0, 1, 0); endtask

  // One tick followed by a quiet cycle.
  task automatic tick(); drive(0, 0, 0, 0, 1); idle(1); endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check("run_en",     32'(o_run_en),     mon_e.run_en);
      check("load",       32'(o_load),       mon_e.load);
      check("edit_field", 32'(o_edit_field), mon_e.field);
      check("blink",      32'(o_blink),      mon_e.blink);
      check("load_hour",  32'(o_load_hour),  mon_e.h);
      check("load_min",   32'(o_load_min),   mon_e.m);
      check("load_sec",   32'(o_load_sec),   mon_e.s);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, scoreboard depth %0d", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    idle(2);

    // Capture 23:59:30, wrap hour both ways, wrap minute down from 0.
    cur_h = 23; cur_m = 59; cur_s = 30;
    press_mode();
    press_up(); press_down(); press_down();
    press_mode();
    press_up(); press_down();
    drive(1, 0, 0, 0, 0);
    idle(2);

    // Full edit to 07:45:00 and commit.
    cur_h = 5; cur_m = 40; cur_s = 12;
    press_mode();
    repeat (2) press_up();
    press_mode();
    repeat (5) press_up();
    press_mode();
    press_up();
    press_mode();
    idle(3);

    // Timeout with no buttons.
    press_mode();
    repeat (TO) tick();
    idle(3);

    // Button on tick 9 restarts the count.
    press_mode();
    repeat (8) tick();
    drive(0, 0, 1, 0, 1);
    repeat (TO - 1) tick();
    tick();
    idle(2);

    // Mode beats up; up+down together is a no-op.
    press_mode();
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 1, 1);
    // Reset asserted while in SET_MIN.
    drive(1, 0, 0, 0, 0);
    idle(2);

    // Out-of-range capture is clamped.
    cur_h = 30; cur_m = 61; cur_s = 63;
    press_mode();
    press_mode(); press_mode(); press_mode();
    idle(2);

    // Randomised traffic with varying button density.
    for (int blk = 0; blk < 40; blk++) begin
      int dens;
      dens = $urandom_range(0, 3);
      for (int c = 0; c < 80; c++) begin
        bit bm, bu, bd, tk, rst;
        bm  = (dens != 0) && ($urandom_range(0, 19) < dens * 2);
        bu  = (dens != 0) && ($urandom_range(0, 19) < dens * 2);
        bd  = (dens != 0) && ($urandom_range(0, 19) < dens * 2);
        tk  = ($urandom_range(0, 2) == 0);
        rst = ($urandom_range(0, 499) == 0);
        cur_h = $urandom_range(0, 31);
        cur_m = $urandom_range(0, 63);
        cur_s = $urandom_range(0, 63);
        drive(rst, bm, bu, bd, tk);
      end
    end

    idle(2);
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Mode controller for the clock's time-keeping datapath. It sequences the second/minute/hour counters between normal running and a user set mode. It freezes the counters while the user edits hour, minute and second fields with debounced button pulses. On commit it issues a one-cycle parallel load, or abandons the edit after an inactivity timeout. It sits between the button debouncers and the counter chain, and drives the blink enable for the display.

## Interface
- P_HOUR_BIT, 5, hour field width
- P_MIN_BIT, 6, minute/second field width
- P_TIMEOUT_SEC, 10, seconds of button inactivity before an edit is abandoned
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- i_one_sec_tick  in  1  one-cycle pulse per second; free-running, not gated by o_run_en
- i_btn_mode  in  1  one-cycle debounced pulse: enter, advance or commit
- i_btn_up  in  1  one-cycle debounced pulse: increment the field
- i_btn_down  in  1  one-cycle debounced pulse: decrement the field
- i_hour  in  P_HOUR_BIT  current hour counter value
- i_min  in  P_MIN_BIT  current minute counter value
- i_sec  in  P_MIN_BIT  current second counter value
- o_run_en  out  1  counters advance only while 1
- o_load  out  1  one-cycle load strobe to all three counters
- o_load_hour  out  P_HOUR_BIT  hour value to load
- o_load_min  out  P_MIN_BIT  minute value to load
- o_load_sec  out  P_MIN_BIT  second value to load
- o_edit_field  out  2  0 none, 1 hour, 2 minute, 3 second
- o_blink  out  1  display blank control for the edited field; 1 = visible

## Operation
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
- RUN
  - o_run_en=1, o_edit_field=0, o_blink=1.
  - Mode pulse: capture i_hour, i_min, i_sec into the edit registers and go to SET_HOUR.
  - Up/down pulses are ignored.
- SET_* states: o_run_en=0.
  - Mode pulse: SET_HOUR→SET_MIN→SET_SEC→COMMIT.
- Hour adjust: up 23→0 wraps, otherwise +1. Down 0→23 wraps, otherwise −1.
- Minute adjust: same rule, modulo 60.
- Second adjust: up or down clears the second field to 0.
- Button priority: mode beats up/down in the same cycle. Up and down together are ignored, but still count as activity.
- COMMIT lasts exactly one cycle.
  - o_load=1 and o_load_* = edit registers.
  - o_run_en=0.
  - Next state is RUN.
- o_load_* hold the edit registers at all times. They are meaningful only while o_load=1.
- Timeout counter
  - Cleared on entry to SET_HOUR and on any button pulse.
  - Incremented on each i_one_sec_tick while in a SET_* state.
  - On reaching P_TIMEOUT_SEC: go to RUN with no load. The counters resume from their frozen values.
  - If a button pulse and the timeout expiry land in the same cycle, the button wins.
- Blink
  - Set to 1 on entry to each SET_* state and on any up/down pulse.
  - Otherwise toggles on each i_one_sec_tick while in a SET_* state.
- Edit registers always hold in-range values: hour 0..23, minute/second 0..59. Captured out-of-range inputs are clamped to 0.

## Timing
- All outputs are registered.
- Reset values: state RUN, o_run_en=1, o_load=0, o_load_* = 0, o_edit_field=0, o_blink=1, timeout counter 0.
- Mode pulse in RUN at cycle n: o_run_en=0 and o_edit_field=1 at n+1.
- Up/down pulse at cycle n: the updated edit value is visible on o_load_* at n+1.
- Mode pulse in SET_SEC at cycle n: o_load=1 at n+1 (COMMIT), then RUN with o_run_en=1 at n+2.
- The counter applies the load at n+1. The first tick after the load is honoured from n+2.
- Timeout: the P_TIMEOUT_SEC-th tick at cycle n gives RUN at n+1.
- Reset asserted mid-edit: RUN on the next edge, edit discarded, no o_load pulse.

## Structure
- Package clock_pkg holds:
  - state enum {RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT}
  - edit-field codes
  - constants HOUR_MAX=23 and MIN_MAX=59
- One sub-module, wrap_updown: parameterized width and max value; inputs value, up, down; output next value. It is combinational and instanced for hour and minute.
- FSM, timeout counter and blink logic live in time_set_ctrl.

## Test plan
- Reset, then mode with i_hour=23, i_min=59, i_sec=30 → edit_field=1, run_en=0, edit hour=23.
- In SET_HOUR: up → 0, down → 23, down → 22. Mode → edit_field=2; down at minute 0 → 59.
- Full edit 07:45:xx, up in SET_SEC, then mode → a single o_load cycle with 7/45/0, followed by run_en=1.
- Enter set, then 10 ticks with no button → RUN, o_load never asserted, run_en=1. A button pulse on tick 9 restarts the count.
- Mode and up in the same cycle in SET_HOUR → advance to SET_MIN, hour unchanged. Up and down together → no change.
- Reset asserted in SET_MIN → RUN next cycle, no o_load, all outputs at their reset values.
